alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: an instruction and its operands are offered.
REQ-005 SHALL have port in_ready, output, 1: the block can accept an instruction.
REQ-006 SHALL have ports instr, rs1_data and rs2_data, input, 32 each: instruction word and register operands.
REQ-007 SHALL have ports alu_a and alu_b, output, 32 each: ALU operand A and operand B (B is the ALU's value_2).
REQ-008 SHALL have port ALU_op, output, 4: ALU operation code.
REQ-009 SHALL have ports ALU_result, input, 32, and alu_zero, input, 1: ALU outputs. For op 0110, alu_zero=0 means the operands are equal.
REQ-010 SHALL have port out_valid, output, 1: a response is available.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the response.
REQ-012 SHALL have ports out_result, output, 32; out_rd, output, 5; out_taken, output, 1; and out_illegal, output, 1.

Function
REQ-013 SHALL implement an FSM with four states: IDLE, DECODE, EXEC and RESP.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, when in_valid=1 and in_ready=1, register instr, rs1_data and rs2_data and go to DECODE.
REQ-016 SHALL decode in DECODE and register the result, then go to EXEC for legal instructions or to RESP for illegal ones.
REQ-017 SHALL decode as follows:
- opcode 0110011 with funct7 0000000: funct3 000 is add (ALU_op 0010), 111 is and (0000), 110 is or (0001); alu_b = rs2.
- opcode 0010011: funct3 000 is addi, 111 is andi, 110 is ori, with the same ALU_op codes; alu_b = sign-extended instr[31:20].
- opcode 1100011 with funct3 000 is beq: ALU_op 0110, alu_b = rs2.
- every other encoding is illegal.
REQ-018 SHALL drive alu_a = registered rs1 and hold ALU_op, alu_a and alu_b stable from DECODE exit until the next acceptance.
REQ-019 SHALL, at the end of the single EXEC cycle, capture the following and then go to RESP:
- ALU and ALU-immediate ops: out_result = ALU_result, out_taken = 0.
- beq: out_result = sign-extended B-immediate, out_taken = ~alu_zero.
REQ-020 SHALL set out_rd = instr[11:7] for ALU ops and 0 for beq and illegal instructions.
REQ-021 SHALL, for an illegal instruction, set out_illegal=1, out_result=0, out_taken=0 and ALU_op=0000.
REQ-022 SHALL drive out_valid=1 only in RESP, and hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-023 SHALL return to IDLE on the cycle out_valid=1 and out_ready=1; no new acceptance occurs in that same cycle.
REQ-024 SHALL have a latency from the acceptance edge to out_valid of 3 cycles for legal and 2 cycles for illegal instructions; out_ready held high gives one instruction per 4 cycles.
REQ-025 SHALL ignore in_valid and input data outside IDLE.

Reset
REQ-026 SHALL, on rst=1 (asynchronously, including mid-operation), force:
- state to IDLE;
- out_valid, out_taken and out_illegal to 0;
- out_result, out_rd, ALU_op, alu_a and alu_b to 0.
REQ-027 SHALL drive in_ready=1 on the first clock edge after rst deasserts.

Configuration
REQ-028 SHALL, with ALU_ISSUE_PERF_EN defined, add outputs perf_issued[31:0] and perf_illegal[31:0], with this behaviour:
- perf_issued increments on each response handshake; perf_illegal increments on handshakes with out_illegal=1.
- both counters wrap at 2^32 and reset to 0.
REQ-029 SHALL, without ALU_ISSUE_PERF_EN, omit these ports and counters entirely, leaving all other behaviour identical.

Structure
REQ-030 SHALL take from shared package alu_issue_pkg:
- ALU_op constants (AND 0000, OR 0001, ADD 0010, SUB 0110);
- opcode constants (OP 0110011, OP_IMM 0010011, BRANCH 1100011);
- the FSM state enum.
REQ-031 SHALL place I- and B-immediate sign extension in the sub-module imm_gen.

Verification
REQ-032 SHALL cover add: instr=0x002081B3, rs1=5, rs2=7 -> ALU_op=0010, out_result=12, out_rd=3, out_valid 3 cycles after acceptance.
REQ-033 SHALL cover addi with a negative immediate: instr=0xFFF08093 (addi x1,x1,-1), rs1=0 -> alu_b=0xFFFFFFFF, out_result=0xFFFFFFFF.
REQ-034 SHALL cover beq: instr=0x00208463, rs1=rs2=9, alu_zero=0 -> out_taken=1, out_result=8; rs2=10, alu_zero=1 -> out_taken=0.
REQ-035 SHALL cover an illegal instruction: instr=0x00000000 -> out_illegal=1 after 2 cycles, ALU_op=0000, and perf_illegal+1 when ALU_ISSUE_PERF_EN is defined.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles -> out_valid and out_* stable, in_ready=0 and a new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover reset mid-operation: rst asserted in EXEC -> out_valid=0 and in_ready=0 immediately, in_ready=1 on the first edge after release, and the captured result is discarded.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, RV32I
// opcode/funct constants, FSM state encoding, decode/response payloads and
// the instruction decode helper.
package alu_issue_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_W   = 7;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

    localparam logic [FUNCT3_W-1:0] F3_ADD = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_AND = 3'b111;
    localparam logic [FUNCT3_W-1:0] F3_OR  = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;

    localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Decoded instruction class; an all-zero value means illegal.
    typedef struct packed {
        logic                legal;
        logic                is_branch;
        logic                use_imm;
        logic [ALU_OP_W-1:0] alu_op;
    } dec_t;

    // Response payload presented on the out_* port group.
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  taken;
        logic                  illegal;
    } resp_t;

    // Classify an instruction from its opcode and function fields.
    function automatic dec_t decode_instr(
        input logic [OPCODE_W-1:0] opcode,
        input logic [FUNCT3_W-1:0] funct3,
        input logic [FUNCT7_W-1:0] funct7
    );
        dec_t d;
        d = '0;
        if ((opcode == OPC_OP && funct7 == F7_BASE) || opcode == OPC_OP_IMM) begin
            d.use_imm = (opcode == OPC_OP_IMM);
            case (funct3)
                F3_ADD: begin d.legal = 1'b1; d.alu_op = ALU_ADD; end
                F3_AND: begin d.legal = 1'b1; d.alu_op = ALU_AND; end
                F3_OR:  begin d.legal = 1'b1; d.alu_op = ALU_OR;  end
                default: d.legal = 1'b0;
            endcase
        end else if (opcode == OPC_BRANCH && funct3 == F3_BEQ) begin
            d.legal     = 1'b1;
            d.is_branch = 1'b1;
            d.alu_op    = ALU_SUB;
        end
        // Illegal encodings collapse to zero so ALU_op reads 0000.
        if (!d.legal) begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_imm_gen.sv
// imm_gen: combinational sign extension of the RV32I I-type and B-type
// immediates.
//   instr_hi : instruction bits [31:20]
//   instr_lo : instruction bits [11:7]
//   i_imm_c  : sign-extended I-immediate
//   b_imm_c  : sign-extended B-immediate (bit 0 always zero)
module imm_gen
    import alu_issue_pkg::*;
(
    input  logic [31:20]       instr_hi,
    input  logic [11:7]        instr_lo,
    output logic [DATA_W-1:0]  i_imm_c,
    output logic [DATA_W-1:0]  b_imm_c
);

    always_comb begin
        i_imm_c = {{20{instr_hi[31]}}, instr_hi[31:20]};
        b_imm_c = {{19{instr_hi[31]}}, instr_hi[31], instr_lo[7],
                   instr_hi[30:25], instr_lo[11:8], 1'b0};
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one RV32I ALU/ALU-immediate/beq instruction at a
// time, decodes it, drives an external ALU and returns a registered response.
// FSM: IDLE -> DECODE -> EXEC -> RESP (illegal: DECODE -> RESP).
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             instruction handshake (ready only in IDLE)
//   instr, rs1_data, rs2_data     instruction word and register operands
//   alu_a, alu_b, ALU_op          ALU operands and op code (held after decode)
//   ALU_result, alu_zero          ALU outputs (alu_zero=0 means equal for SUB)
//   out_valid/out_ready           response handshake
//   out_result, out_rd,
//   out_taken, out_illegal        response fields
// Optional: define ALU_ISSUE_PERF_EN to add perf_issued/perf_illegal counters.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       instr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [ALU_OP_W-1:0]   ALU_op,
    input  logic [XLEN-1:0]       ALU_result,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_taken,
    output logic                  out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_illegal
`endif
);

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    // rs1 field [19:15] is never needed, so only the used slices are kept.
    logic [31:20]          instr_hi_q, instr_hi_d;
    logic [14:0]           instr_lo_q, instr_lo_d;
    logic [XLEN-1:0]       rs1_q, rs1_d;
    logic [XLEN-1:0]       rs2_q, rs2_d;
    logic                  is_branch_q, is_branch_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [XLEN-1:0]       alu_a_q, alu_a_d;
    logic [XLEN-1:0]       alu_b_q, alu_b_d;
    resp_t                 resp_q, resp_d;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]           perf_issued_q, perf_issued_d;
    logic [31:0]           perf_illegal_q, perf_illegal_d;
`endif

    dec_t                  dec_c;
    logic [DATA_W-1:0]     i_imm_c;
    logic [DATA_W-1:0]     b_imm_c;

    imm_gen u_imm_gen (
        .instr_hi (instr_hi_q),
        .instr_lo (instr_lo_q[11:7]),
        .i_imm_c  (i_imm_c),
        .b_imm_c  (b_imm_c)
    );

    // Decode of the registered instruction.
    always_comb begin
        dec_c = decode_instr(instr_lo_q[6:0], instr_lo_q[14:12], instr_hi_q[31:25]);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        instr_hi_d  = instr_hi_q;
        instr_lo_d  = instr_lo_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        is_branch_d = is_branch_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        resp_d      = resp_q;
`ifdef ALU_ISSUE_PERF_EN
        perf_issued_d  = perf_issued_q;
        perf_illegal_d = perf_illegal_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    instr_hi_d = instr[31:20];
                    instr_lo_d = instr[14:0];
                    rs1_d      = rs1_data;
                    rs2_d      = rs2_data;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op_d    = dec_c.alu_op;
                alu_a_d     = rs1_q;
                alu_b_d     = dec_c.use_imm ? i_imm_c : rs2_q;
                is_branch_d = dec_c.is_branch;
                if (dec_c.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    resp_d         = '0;
                    resp_d.illegal = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_EXEC: begin
                resp_d.illegal = 1'b0;
                if (is_branch_q) begin
                    resp_d.result = b_imm_c;
                    resp_d.rd     = '0;
                    // ALU flag is inverted for SUB: zero flag low means equal.
                    resp_d.taken  = ~alu_zero;
                end else begin
                    resp_d.result = ALU_result;
                    resp_d.rd     = instr_lo_q[11:7];
                    resp_d.taken  = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef ALU_ISSUE_PERF_EN
                    perf_issued_d = perf_issued_q + 32'd1;
                    if (resp_q.illegal) begin
                        perf_illegal_d = perf_illegal_q + 32'd1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flags follow the next state so they line up with it.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; in_ready stays low while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_hi_q  <= '0;
            instr_lo_q  <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            is_branch_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            resp_q      <= '0;
`ifdef ALU_ISSUE_PERF_EN
            perf_issued_q  <= '0;
            perf_illegal_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            instr_hi_q  <= instr_hi_d;
            instr_lo_q  <= instr_lo_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            is_branch_q <= is_branch_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            resp_q      <= resp_d;
`ifdef ALU_ISSUE_PERF_EN
            perf_issued_q  <= perf_issued_d;
            perf_illegal_q <= perf_illegal_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign ALU_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign out_result  = resp_q.result;
    assign out_rd      = resp_q.rd;
    assign out_taken   = resp_q.taken;
    assign out_illegal = resp_q.illegal;
`ifdef ALU_ISSUE_PERF_EN
    assign perf_issued  = perf_issued_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr, rs1_data, rs2_data;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  ALU_op;
    logic [31:0] ALU_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_taken;
    logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_illegal;
    logic [31:0] exp_issued, exp_illegal;
`endif

    int n_total;
    int n_pass;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .ALU_op      (ALU_op),
        .ALU_result  (ALU_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_taken   (out_taken),
        .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_illegal (perf_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; alu_zero is driven directly by the stimulus.
    always_comb begin
        case (ALU_op)
            4'b0010: ALU_result = alu_a + alu_b;
            4'b0000: ALU_result = alu_a & alu_b;
            4'b0001: ALU_result = alu_a | alu_b;
            4'b0110: ALU_result = alu_a - alu_b;
            default: ALU_result = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one instruction, measure latency, check the response, optionally
    // hold out_ready low for 'hold' cycles while offering a second instruction.
    task automatic run_txn(input string tag, input logic [31:0] ins,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic az_v, input int exp_lat,
                           input logic [31:0] exp_res, input logic [4:0] exp_rd,
                           input logic exp_taken, input logic exp_ill,
                           input logic [3:0] exp_op, input logic [31:0] exp_b,
                           input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
        alu_zero = az_v;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        instr    = 32'hDEADBEEF;
        rs1_data = 32'hA5A5A5A5;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".result"},  out_result, exp_res);
        chk({tag, ".rd"},      32'(out_rd), 32'(exp_rd));
        chk({tag, ".taken"},   32'(out_taken), 32'(exp_taken));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(exp_ill));
        chk({tag, ".alu_op"},  32'(ALU_op), 32'(exp_op));
        chk({tag, ".alu_a"},   alu_a, r1);
        chk({tag, ".alu_b"},   alu_b, exp_b);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = 32'h0020F1B3;
            rs1_data = 32'h1111;
            rs2_data = 32'h2222;
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"},  32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, out_result, exp_res);
            chk({tag, ".hold_rd"},     32'(out_rd), 32'(exp_rd));
            chk({tag, ".hold_ready"},  32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        exp_issued = exp_issued + 32'd1;
        if (exp_ill) exp_illegal = exp_illegal + 32'd1;
        chk({tag, ".perf_issued"},  perf_issued,  exp_issued);
        chk({tag, ".perf_illegal"}, perf_illegal, exp_illegal);
`endif
    endtask

    initial begin
        logic saw_valid;
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        alu_zero  = 1'b0;
        out_ready = 1'b0;
`ifdef ALU_ISSUE_PERF_EN
        exp_issued  = '0;
        exp_illegal = '0;
`endif
        #2;
        chk("rst.in_ready",  32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    out_result, 32'd0);
        chk("rst.alu_op",    32'(ALU_op), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        //      tag       instr          rs1           rs2           az  lat result        rd  tk ill op     alu_b         hold
        run_txn("add",    32'h002081B3,  32'd5,        32'd7,        0,  3,  32'd12,       3,  0, 0,  4'h2, 32'd7,        0);
        run_txn("addi",   32'hFFF08093,  32'd0,        32'd0,        0,  3,  32'hFFFFFFFF, 1,  0, 0,  4'h2, 32'hFFFFFFFF, 0);
        run_txn("beq_t",  32'h00208463,  32'd9,        32'd9,        0,  3,  32'd8,        0,  1, 0,  4'h6, 32'd9,        0);
        run_txn("beq_nt", 32'h00208463,  32'd9,        32'd10,       1,  3,  32'd8,        0,  0, 0,  4'h6, 32'd10,       0);
        run_txn("ill0",   32'h00000000,  32'd0,        32'd0,        0,  2,  32'd0,        0,  0, 1,  4'h0, 32'd0,        0);
        run_txn("and",    32'h0020F1B3,  32'h0000F0F0, 32'h00000FF0, 0,  3,  32'h000000F0, 3,  0, 0,  4'h0, 32'h00000FF0, 0);
        run_txn("ori",    32'h7FF06293,  32'h00000100, 32'h00005555, 0,  3,  32'h000007FF, 5,  0, 0,  4'h1, 32'h000007FF, 0);
        run_txn("andi",   32'hFF01F113,  32'h00001234, 32'd0,        0,  3,  32'h00001230, 2,  0, 0,  4'h0, 32'hFFFFFFF0, 0);
        run_txn("sub_il", 32'h400081B3,  32'd0,        32'd0,        0,  2,  32'd0,        0,  0, 1,  4'h0, 32'd0,        0);
        run_txn("bp_add", 32'h002081B3,  32'h10,       32'h20,       0,  3,  32'h30,       3,  0, 0,  4'h2, 32'h20,       5);

        // Reset asserted while in EXEC discards the in-flight result.
        @(negedge clk);
        instr     = 32'h002081B3;
        rs1_data  = 32'd40;
        rs2_data  = 32'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.alu_op_exec", 32'(ALU_op), 32'h2);
        rst = 1'b1;
        #1;
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.in_ready",  32'(in_ready), 32'd0);
        chk("mid.alu_op",    32'(ALU_op), 32'd0);
        chk("mid.alu_a",     alu_a, 32'd0);
        chk("mid.alu_b",     alu_b, 32'd0);
        chk("mid.result",    out_result, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("mid.perf_issued", perf_issued, 32'd0);
        exp_issued  = '0;
        exp_illegal = '0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.rel_ready", 32'(in_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mid.discarded", 32'(saw_valid), 32'd0);
        chk("mid.result_0",  out_result, 32'd0);

        run_txn("recov",  32'h002081B3,  32'd100,      32'd23,       0,  3,  32'd123,      3,  0, 0,  4'h2, 32'd23,       0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
